seg7_scan_mux: RTL and testbench

Parametrised time-multiplexed hex driver for common-anode 7-segment displays. It scans `DIGITS` digits from a fast system clock through an internal prescaler. It snapshots the display word once per frame so all digits show a coherent value, and inserts a programmable anode-off guard interval at each digit change to suppress ghosting. It sits between any status/debug word in the design and the board's `seg`/`an`/`dp` pins.

---
 rtl/seg7_if.sv | 23 ++
 rtl/seg7_scan_mux.sv | 90 +++++++++
 tb/tb_seg7_scan_mux.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seg7_if.sv
// seg7_if: display-side bus of the 7-segment scan multiplexer.
//   value    - hex word, nibble i drives digit i (digit 0 rightmost)
//   dp_in    - decimal-point request per digit, 1 = lit
//   digit_en - per-digit enable, 0 keeps that anode off
//   seg      - segments a..g on seg[0]..seg[6], active low
//   an       - anode selects, active low, at most one low
//   dp       - decimal point, active low
//   frame    - one-cycle pulse when the snapshot registers load
// master drives the word and enables; slave is the scan multiplexer.
interface seg7_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   digit_en;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                dp;
    logic                frame;

    modport master (output value, dp_in, digit_en, input seg, an, dp, frame);
    modport slave  (input value, dp_in, digit_en, output seg, an, dp, frame);
endinterface

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed hex driver for common-anode 7-segment displays.
//   clk   - system clock, all state on the rising edge
//   reset - asynchronous active-high reset
//   bus   - seg7_if.slave: value/dp_in/digit_en in, seg/an/dp/frame out
// DIGITS digits are scanned, CLK_DIV clocks per slot, the first BLANK clocks of
// each slot keep every anode off. Inputs are snapshotted once per frame.
// Define SEG7_LZB_EN to enable leading-zero blanking of digits 1..DIGITS-1.
module seg7_scan_mux #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 10000,
    parameter int BLANK   = 100
) (
    input logic   clk,
    input logic   reset,
    seg7_if.slave bus
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    // lit segments per hex value, gfedcba, digit 0 in the low bits
    localparam logic [16*7-1:0] LIT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    logic [DW-1:0]       div_q, div_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_val_q;
    logic [DIGITS-1:0]   snap_dp_q, snap_en_q;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                dp_q, dp_d, frame_q;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          nib;
    logic                wrap, last, past_blank, active;

`ifdef SEG7_LZB_EN
    // a digit goes dark when it and every digit to its left hold zero
    assign blank[0] = 1'b0;
    for (genvar i = 1; i < DIGITS; i++) begin : g_lzb
        assign blank[i] = snap_val_q[4*DIGITS-1:4*i] == '0;
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        wrap       = div_q == DW'(CLK_DIV - 1);
        last       = wrap && idx_q == IW'(DIGITS - 1);
        div_d      = wrap ? '0 : div_q + DW'(1);
        idx_d      = !wrap ? idx_q : (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1));
        // written as div+1 > BLANK so BLANK=0 is not a constant comparison
        past_blank = ({1'b0, div_q} + (DW+1)'(1)) > (DW+1)'(BLANK);
        active     = past_blank && snap_en_q[idx_q] && !blank[idx_q];
        nib        = snap_val_q[{idx_q, 2'b00} +: 4];
        seg_d      = active ? ~LIT[7*nib +: 7] : 7'h7F;
        an_d       = active ? ~(DIGITS'(1) << idx_q) : '1;
        dp_d       = active ? ~snap_dp_q[idx_q] : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            idx_q      <= '0;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            snap_en_q  <= '0;
            seg_q      <= 7'h7F;
            an_q       <= '1;
            dp_q       <= 1'b1;
            frame_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            frame_q <= last;
            if (last) begin
                snap_val_q <= bus.value;
                snap_dp_q  <= bus.dp_in;
                snap_en_q  <= bus.digit_en;
            end
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.dp    = dp_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: randomized scoreboard bench for seg7_scan_mux.
module tb_seg7_scan_mux;
    localparam int D = 4, C = 8, B = 2, N = D * C;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
        logic [3:0]  e;
    } desc_t;

    logic clk = 1'b0, reset = 1'b0;
    seg7_if #(.DIGITS(D)) bus ();
    seg7_if #(.DIGITS(1)) bus1 ();

    seg7_scan_mux #(.DIGITS(D), .CLK_DIV(C), .BLANK(B)) dut (.clk(clk), .reset(reset), .bus(bus));
    seg7_scan_mux #(.DIGITS(1), .CLK_DIV(2), .BLANK(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    always #5 clk = ~clk;

    string GL [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    desc_t q[$];
    desc_t cur;
    int pos, e1, k, n_cmp, n_bad;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        string s = GL[n];
        logic [6:0] g = '0;
        for (int i = 0; i < s.len(); i++) g[s[i] - 8'd97] = 1'b1;
        return g;
    endfunction

    // expected {an, seg, dp} at position p (0..N-1) of a frame showing s
    function automatic logic [11:0] model(input desc_t s, input int p);
        int i = p / C;
        int sub = p % C;
        logic [3:0] nib = 4'(s.v >> (4 * i));
        bit lit = s.e[i] && sub >= B;
`ifdef SEG7_LZB_EN
        if (i > 0 && (s.v >> (4 * i)) == 16'h0) lit = 0;
`endif
        return lit ? {~(4'b1 << i), ~glyph(nib), ~s.d[i]} : {4'hF, 7'h7F, 1'b1};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // main monitor: pops one snapshot per frame pulse and checks every scan cycle
    always @(negedge clk) begin
        if (reset) begin
            cur = '{16'h0, 4'h0, 4'h0};
            pos = -2;
            chk("reset_outs", {bus.an, bus.seg, bus.dp, bus.frame}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end else begin
            pos++;
            if (pos >= 0) begin
                chk("scan", {bus.an, bus.seg, bus.dp}, model(cur, pos));
                chk("one_anode", 32'($countones(~bus.an) <= 1), 32'd1);
            end
            chk("frame", bus.frame, pos == N - 1);
            if (bus.frame) begin
                if (q.size() == 0) chk("queue_empty", 0, 1);
                else cur = q.pop_front();
                pos = -1;
            end
        end
    end

    // single-digit instance: constant digit 7 with dp lit
    always @(negedge clk) begin
        if (reset) e1 = -1;
        else begin
            e1++;
            chk("d1", {bus1.an, bus1.seg, bus1.dp, bus1.frame},
                {e1 >= 3 ? {1'b0, ~glyph(4'h7), 1'b0} : {1'b1, 7'h7F, 1'b1}, e1 > 0 && e1 % 2 == 0});
        end
    end

    task automatic tick();
        @(posedge clk);
        k++;
        if (k % N == 0) q.push_back('{bus.value, bus.dp_in, bus.digit_en});
        #1;
    endtask

    task automatic run_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e,
                             input bit mid, input logic [15:0] v2);
        bus.value = v;
        bus.dp_in = d;
        bus.digit_en = e;
        for (int i = 0; i < N; i++) begin
            tick();
            if (mid && i == N / 2) bus.value = v2;
        end
    endtask

    task automatic rand_frame();
        bus.value = 16'($urandom);
        bus.dp_in = 4'($urandom);
        bus.digit_en = 4'($urandom);
        for (int i = 0; i < N; i++) begin
            tick();
            case ($urandom_range(0, 7))
                0: bus.value = 16'($urandom);
                1: bus.dp_in = 4'($urandom);
                2: bus.digit_en = 4'($urandom);
                default: ;
            endcase
        end
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: run did not end, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.value = '0;
        bus.dp_in = '0;
        bus.digit_en = '0;
        bus1.value = 4'h7;
        bus1.dp_in = 1'b1;
        bus1.digit_en = 1'b1;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        k = 0;
        run_frame(16'h12AF, 4'b0100, 4'hF, 0, 16'h0);
        run_frame(16'h12AF, 4'b0100, 4'hF, 0, 16'h0);
        run_frame(16'h1234, 4'b0000, 4'hF, 0, 16'h0);
        run_frame(16'h1234, 4'b0000, 4'hF, 1, 16'h5678);
        run_frame(16'h5678, 4'b1001, 4'b1010, 0, 16'h0);
        run_frame(16'h0030, 4'b0000, 4'hF, 0, 16'h0);
        run_frame(16'h0000, 4'b0001, 4'hF, 0, 16'h0);
        run_frame(16'hF00E, 4'b1111, 4'hF, 0, 16'h0);
        for (int f = 0; f < 16; f++) rand_frame();
        run_frame(16'h9BCD, 4'b0100, 4'hF, 0, 16'h0);
        run_frame(16'h9BCD, 4'b0100, 4'hF, 0, 16'h0);
        begin
            int w = 0;
            while (bus.an !== 4'b1011 && w < 100) begin
                tick();
                w++;
            end
            chk("wait_an2", bus.an, 4'b1011);
        end
        #1 reset = 1'b1;
        #1 chk("async_reset", {bus.an, bus.seg, bus.dp, bus.frame}, {4'hF, 7'h7F, 1'b1, 1'b0});
        q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        k = 0;
        run_frame(16'h4321, 4'b0010, 4'hF, 0, 16'h0);
        run_frame(16'h0A00, 4'b1000, 4'hF, 1, 16'h00B0);
        run_frame(16'hC0DE, 4'b0000, 4'b0111, 0, 16'h0);
        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
